vend_engine: RTL and testbench

Parametrised vending transaction engine for the Basys 3 vending machine: an N-item controller with credit accumulation, per-item stock counters, a handshaked product dispenser and coin-by-coin change return. It sits between the coin handler, the debounced purchase/cancel buttons and the display, LED and sound blocks. It adds item-count scaling, saturating credit, cancel/refund and paced change output.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/change_dispenser.sv | 65 ++++++
 rtl/vend_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_vend_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - state encodings, error codes and change denominations for vend_engine
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_CHECK  = 3'd2,
    ST_VEND   = 3'd3,
    ST_CHANGE = 3'd4
  } vend_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_FUNDS    = 2'd1;
  localparam logic [1:0] ERR_SOLD_OUT = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  localparam logic [7:0] COIN_BIG   = 8'd5;
  localparam logic [7:0] COIN_MID   = 8'd2;
  localparam logic [7:0] COIN_SMALL = 8'd1;

  function automatic logic [7:0] greedy_coin(input logic [7:0] amount);
    logic [7:0] coin;
    if (amount >= COIN_BIG)      coin = COIN_BIG;
    else if (amount >= COIN_MID) coin = COIN_MID;
    else                         coin = COIN_SMALL;
    return coin;
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy change coin output with paced handshake
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CHANGE_GAP = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] amount_i,
  input  logic       chg_ack_i,
  output logic       chg_valid_o,
  output logic [7:0] chg_value_o,
  output logic [7:0] dec_o,
  output logic       done_o
);

  // At least one idle cycle so valid always drops after an ack.
  localparam int GAP_LOAD = (CHANGE_GAP < 1) ? 1 : CHANGE_GAP;
  localparam int GAP_W    = $clog2(GAP_LOAD + 2);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_LOAD);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic [7:0]       amount_q, amount_d;
  logic             valid_q, valid_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             take;

  assign chg_value_o = greedy_coin(amount_q);
  assign chg_valid_o = valid_q;
  assign take        = valid_q & chg_ack_i;
  assign dec_o       = take ? chg_value_o : 8'd0;
  assign done_o      = take & (amount_q == chg_value_o);

  always_comb begin
    amount_d = amount_q;
    valid_d  = valid_q;
    gap_d    = gap_q;
    if (start_i) begin
      amount_d = amount_i;
      valid_d  = (amount_i != 8'd0);
      gap_d    = '0;
    end else if (take) begin
      amount_d = amount_q - chg_value_o;
      valid_d  = 1'b0;
      gap_d    = (amount_q == chg_value_o) ? '0 : GAP_INIT;
    end else if (gap_q != '0) begin
      gap_d   = gap_q - GAP_ONE;
      valid_d = (gap_q == GAP_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amount_q <= 8'd0;
      valid_q  <= 1'b0;
      gap_q    <= '0;
    end else begin
      amount_q <= amount_d;
      valid_q  <= valid_d;
      gap_q    <= gap_d;
    end
  end

endmodule

// File: rtl/vend_engine.sv
// rtl/vend_engine.sv - N-item vending transaction engine: credit, stock, dispense, change
// Optional inactivity auto-refund is built when VEND_TIMEOUT_EN is defined.
module vend_engine
  import vend_pkg::*;
#(
  parameter int N_ITEMS        = 4,
  parameter int MAX_STOCK      = 15,
  parameter int STOCK_W        = 4,
  parameter int CREDIT_MAX     = 99,
  parameter int CHANGE_GAP     = 1000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coin_valid,
  input  logic [7:0]                   coin_value,
  output logic                         coin_ready,
  output logic                         coin_reject,
  input  logic                         purchase_req,
  input  logic                         cancel_req,
  input  logic [$clog2(N_ITEMS)-1:0]   item_sel,
  input  logic [8*N_ITEMS-1:0]         price_bus,
  input  logic                         restock,
  output logic                         vend_valid,
  output logic [$clog2(N_ITEMS)-1:0]   vend_item,
  input  logic                         vend_ack,
  output logic                         chg_valid,
  output logic [7:0]                   chg_value,
  input  logic                         chg_ack,
  output logic [7:0]                   credit,
  output logic [STOCK_W*N_ITEMS-1:0]   stock_bus,
  output logic [N_ITEMS-1:0]           sold_out,
  output logic                         err_pulse,
  output logic [1:0]                   err_code,
  output logic [2:0]                   state
);

  localparam int SEL_W = $clog2(N_ITEMS);
  localparam logic [8:0]         CREDIT_CAP = 9'(CREDIT_MAX);
  localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(MAX_STOCK);

  if (TIMEOUT_CYCLES < 1 || MAX_STOCK >= (1 << STOCK_W)) begin : g_bad_cfg
    $error("vend_engine: invalid TIMEOUT_CYCLES or STOCK_W too narrow for MAX_STOCK");
  end

  vend_state_e        state_q, state_d;
  logic [7:0]         credit_q, credit_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [7:0]         price_q, price_d;
  logic [STOCK_W-1:0] stock_q [N_ITEMS];
  logic [STOCK_W-1:0] stock_d [N_ITEMS];
  logic               err_pulse_q, err_pulse_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               reject_q, reject_d;

  logic [7:0] price_arr [N_ITEMS];
  logic       coin_take, coin_fits;
  logic [8:0] coin_sum;
  logic [7:0] credit_in;
  logic       chg_start, chg_done;
  logic [7:0] chg_amount, chg_dec;
  logic       timed_out;

  for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
    assign price_arr[i] = price_bus[8*i +: 8];
    assign stock_bus[STOCK_W*i +: STOCK_W] = stock_q[i];
    assign sold_out[i] = (stock_q[i] == '0);
  end

  assign coin_ready = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
  assign coin_take  = coin_valid & coin_ready;
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_fits  = (coin_sum <= CREDIT_CAP);
  assign credit_in  = (coin_take && coin_fits) ? coin_sum[7:0] : credit_q;

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            activity;

  assign activity  = coin_valid | purchase_req | cancel_req;
  assign timed_out = (state_q == ST_CREDIT) && !activity && (to_q == TO_W'(TIMEOUT_CYCLES));

  always_comb begin
    to_d = to_q;
    if (state_q != ST_CREDIT || activity) to_d = '0;
    else if (to_q != TO_W'(TIMEOUT_CYCLES)) to_d = to_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_q <= '0;
    else      to_q <= to_d;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    sel_d       = sel_q;
    price_d     = price_q;
    stock_d     = stock_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    reject_d    = 1'b0;
    chg_start   = 1'b0;
    chg_amount  = credit_q;

    if (coin_take && !coin_fits) begin
      reject_d    = 1'b1;
      err_pulse_d = 1'b1;
      err_code_d  = ERR_OVERFLOW;
    end
    if (coin_ready && restock) begin
      for (int i = 0; i < N_ITEMS; i++) stock_d[i] = STOCK_FULL;
    end

    case (state_q)
      ST_IDLE: begin
        credit_d = credit_in;
        if (coin_take && coin_fits) state_d = ST_CREDIT;
        if (purchase_req) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_FUNDS;
        end
      end
      ST_CREDIT: begin
        credit_d = credit_in;
        if (cancel_req || timed_out) begin
          if (credit_in != 8'd0) begin
            state_d    = ST_CHANGE;
            chg_start  = 1'b1;
            chg_amount = credit_in;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (purchase_req) begin
          state_d = ST_CHECK;
          sel_d   = item_sel;
        end
      end
      ST_CHECK: begin
        if (stock_q[sel_q] == '0) begin
          state_d     = ST_CREDIT;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_SOLD_OUT;
        end else if (credit_q < price_arr[sel_q]) begin
          state_d     = ST_CREDIT;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_FUNDS;
        end else begin
          price_d = price_arr[sel_q];
          state_d = ST_VEND;
        end
      end
      ST_VEND: begin
        if (vend_ack) begin
          if (stock_q[sel_q] != '0) stock_d[sel_q] = stock_q[sel_q] - STOCK_W'(1);
          credit_d = credit_q - price_q;
          if (credit_q != price_q) begin
            state_d    = ST_CHANGE;
            chg_start  = 1'b1;
            chg_amount = credit_q - price_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_CHANGE: begin
        credit_d = credit_q - chg_dec;
        if (chg_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      credit_q    <= 8'd0;
      sel_q       <= '0;
      price_q     <= 8'd0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      reject_q    <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_FULL;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      sel_q       <= sel_d;
      price_q     <= price_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      reject_q    <= reject_d;
      stock_q     <= stock_d;
    end
  end

  change_dispenser #(.CHANGE_GAP(CHANGE_GAP)) u_change (
    .clk        (clk),
    .rst_n      (rst),
    .start_i    (chg_start),
    .amount_i   (chg_amount),
    .chg_ack_i  (chg_ack),
    .chg_valid_o(chg_valid),
    .chg_value_o(chg_value),
    .dec_o      (chg_dec),
    .done_o     (chg_done)
  );

  assign vend_valid  = (state_q == ST_VEND);
  assign vend_item   = sel_q;
  assign credit      = credit_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;
  assign coin_reject = reject_q;
  assign state       = state_q;

endmodule

// File: tb/tb_vend_engine.sv
// tb/tb_vend_engine.sv - directed self-checking bench for vend_engine
module tb_vend_engine;

  localparam int GAP = 50;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        coin_valid, purchase_req, cancel_req, restock, vend_ack, chg_ack;
  logic [7:0]  coin_value;
  logic [1:0]  item_sel;
  logic [31:0] price_bus;
  logic        coin_ready, coin_reject, vend_valid, chg_valid, err_pulse;
  logic [1:0]  vend_item, err_code;
  logic [7:0]  chg_value, credit;
  logic [15:0] stock_bus;
  logic [3:0]  sold_out;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vend_engine #(
    .N_ITEMS(4), .MAX_STOCK(15), .STOCK_W(4), .CREDIT_MAX(99),
    .CHANGE_GAP(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(coin_ready), .coin_reject(coin_reject),
    .purchase_req(purchase_req), .cancel_req(cancel_req), .item_sel(item_sel), .price_bus(price_bus),
    .restock(restock), .vend_valid(vend_valid), .vend_item(vend_item), .vend_ack(vend_ack),
    .chg_valid(chg_valid), .chg_value(chg_value), .chg_ack(chg_ack), .credit(credit),
    .stock_bus(stock_bus), .sold_out(sold_out), .err_pulse(err_pulse), .err_code(err_code), .state(state)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();
  endtask

  task automatic coin(input logic [7:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (credit !== 8'd0) begin bad++; $display("FAIL reset_credit got=%0d exp=0", credit); end
    total++; if (stock_bus !== 16'hFFFF) begin bad++; $display("FAIL reset_stock got=%h exp=ffff", stock_bus); end
    total++; if (sold_out !== 4'b0) begin bad++; $display("FAIL reset_sold_out got=%b exp=0000", sold_out); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
    total++; if ({vend_valid, chg_valid, err_pulse, coin_reject} !== 4'b0) begin
      bad++; $display("FAIL reset_pulses got=%b exp=0000", {vend_valid, chg_valid, err_pulse, coin_reject});
    end
    total++; if (coin_ready !== 1'b1) begin bad++; $display("FAIL reset_coin_ready got=%b exp=1", coin_ready); end
  endtask

  task automatic test_idle_purchase();
    purchase_req = 1'b1;
    tick();
    purchase_req = 1'b0;
    total++; if ({err_pulse, err_code} !== 3'b1_01) begin bad++; $display("FAIL idle_purchase_err got=%b exp=101", {err_pulse, err_code}); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL idle_purchase_state got=%0d exp=0", state); end
    tick();
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL idle_purchase_pulse_len got=%b exp=0", err_pulse); end
  endtask

  task automatic test_purchase();
    coin(8'd5);
    total++; if ({state, credit} !== {3'd1, 8'd5}) begin bad++; $display("FAIL buy_coin5 state=%0d credit=%0d exp 1/5", state, credit); end
    coin(8'd2);
    total++; if (credit !== 8'd7) begin bad++; $display("FAIL buy_coin2 got=%0d exp=7", credit); end
    item_sel = 2'd0;
    purchase_req = 1'b1;
    tick();
    purchase_req = 1'b0;
    total++; if (state !== 3'd2) begin bad++; $display("FAIL buy_check got=%0d exp=2", state); end
    tick();
    total++; if ({state, vend_valid, vend_item} !== {3'd3, 1'b1, 2'd0}) begin
      bad++; $display("FAIL buy_vend state=%0d valid=%b item=%0d exp 3/1/0", state, vend_valid, vend_item);
    end
    tick(2);
    total++; if ({vend_valid, stock_bus} !== {1'b1, 16'hFFFF}) begin
      bad++; $display("FAIL buy_vend_hold valid=%b stock=%h exp 1/ffff", vend_valid, stock_bus);
    end
    vend_ack = 1'b1;
    tick();
    vend_ack = 1'b0;
    total++; if (stock_bus !== 16'hFFFE) begin bad++; $display("FAIL buy_stock got=%h exp=fffe", stock_bus); end
    total++; if ({state, credit, vend_valid} !== {3'd4, 8'd1, 1'b0}) begin
      bad++; $display("FAIL buy_after_ack state=%0d credit=%0d vvalid=%b exp 4/1/0", state, credit, vend_valid);
    end
    total++; if ({chg_valid, chg_value} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL buy_change valid=%b value=%0d exp 1/1", chg_valid, chg_value);
    end
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
    total++; if ({state, credit, chg_valid} !== {3'd0, 8'd0, 1'b0}) begin
      bad++; $display("FAIL buy_done state=%0d credit=%0d cvalid=%b exp 0/0/0", state, credit, chg_valid);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    coin(8'd97);
    total++; if (credit !== 8'd97) begin bad++; $display("FAIL ovf_load got=%0d exp=97", credit); end
    coin(8'd5);
    total++; if ({coin_reject, err_pulse, err_code} !== 4'b1_1_11) begin
      bad++; $display("FAIL ovf_reject got=%b exp=1111", {coin_reject, err_pulse, err_code});
    end
    total++; if ({state, credit} !== {3'd1, 8'd97}) begin bad++; $display("FAIL ovf_credit state=%0d credit=%0d exp 1/97", state, credit); end
    coin(8'd2);
    total++; if ({coin_reject, credit, err_code} !== {1'b0, 8'd99, 2'd3}) begin
      bad++; $display("FAIL ovf_edge reject=%b credit=%0d code=%0d exp 0/99/3", coin_reject, credit, err_code);
    end
    apply_reset();
  endtask

  task automatic test_sold_out();
    item_sel = 2'd1;
    for (int i = 0; i < 15; i++) begin
      coin(8'd3);
      purchase_req = 1'b1;
      tick();
      purchase_req = 1'b0;
      tick();
      vend_ack = 1'b1;
      tick();
      vend_ack = 1'b0;
    end
    total++; if ({stock_bus, sold_out, state} !== {16'hFF0F, 4'b0010, 3'd0}) begin
      bad++; $display("FAIL drain stock=%h sold=%b state=%0d exp ff0f/0010/0", stock_bus, sold_out, state);
    end
    coin(8'd5);
    purchase_req = 1'b1;
    tick();
    purchase_req = 1'b0;
    tick();
    total++; if ({err_pulse, err_code, state, credit} !== {1'b1, 2'd2, 3'd1, 8'd5}) begin
      bad++; $display("FAIL soldout_err pulse=%b code=%0d state=%0d credit=%0d exp 1/2/1/5", err_pulse, err_code, state, credit);
    end
    item_sel = 2'd2;
    purchase_req = 1'b1;
    tick();
    purchase_req = 1'b0;
    tick();
    total++; if ({err_pulse, err_code, state, credit} !== {1'b1, 2'd1, 3'd1, 8'd5}) begin
      bad++; $display("FAIL funds_err pulse=%b code=%0d state=%0d credit=%0d exp 1/1/1/5", err_pulse, err_code, state, credit);
    end
    restock = 1'b1;
    tick();
    restock = 1'b0;
    total++; if ({stock_bus, sold_out} !== {16'hFFFF, 4'b0}) begin
      bad++; $display("FAIL restock stock=%h sold=%b exp ffff/0000", stock_bus, sold_out);
    end
    cancel_req = 1'b1;
    tick();
    cancel_req = 1'b0;
    total++; if ({state, chg_valid, chg_value} !== {3'd4, 1'b1, 8'd5}) begin
      bad++; $display("FAIL refund5 state=%0d valid=%b value=%0d exp 4/1/5", state, chg_valid, chg_value);
    end
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
    total++; if ({state, credit} !== {3'd0, 8'd0}) begin bad++; $display("FAIL refund5_done state=%0d credit=%0d exp 0/0", state, credit); end
  endtask

  task automatic test_cancel_change();
    logic [7:0] exp_coin [3];
    int gap;
    exp_coin[0] = 8'd5; exp_coin[1] = 8'd2; exp_coin[2] = 8'd1;
    coin(8'd8);
    cancel_req = 1'b1;
    tick();
    cancel_req = 1'b0;
    total++; if ({state, credit} !== {3'd4, 8'd8}) begin bad++; $display("FAIL cancel state=%0d credit=%0d exp 4/8", state, credit); end
    for (int c = 0; c < 3; c++) begin
      total++; if ({chg_valid, chg_value} !== {1'b1, exp_coin[c]}) begin
        bad++; $display("FAIL chg_coin%0d valid=%b value=%0d exp 1/%0d", c, chg_valid, chg_value, exp_coin[c]);
      end
      tick(3);
      total++; if ({chg_valid, chg_value} !== {1'b1, exp_coin[c]}) begin
        bad++; $display("FAIL chg_hold%0d valid=%b value=%0d exp 1/%0d", c, chg_valid, chg_value, exp_coin[c]);
      end
      chg_ack = 1'b1;
      tick();
      chg_ack = 1'b0;
      if (c < 2) begin
        gap = 1;
        while (!chg_valid && gap < 4 * GAP) begin
          tick();
          if (!chg_valid) gap++;
        end
        total++; if (gap !== GAP) begin bad++; $display("FAIL chg_gap%0d got=%0d exp=%0d", c, gap, GAP); end
      end
    end
    total++; if ({state, credit, chg_valid} !== {3'd0, 8'd0, 1'b0}) begin
      bad++; $display("FAIL cancel_done state=%0d credit=%0d valid=%b exp 0/0/0", state, credit, chg_valid);
    end
  endtask

  task automatic test_vend_abort();
    item_sel = 2'd0;
    coin(8'd6);
    purchase_req = 1'b1;
    tick();
    purchase_req = 1'b0;
    tick(20);
    total++; if ({state, vend_valid, stock_bus} !== {3'd3, 1'b1, 16'hFFFF}) begin
      bad++; $display("FAIL abort_wait state=%0d valid=%b stock=%h exp 3/1/ffff", state, vend_valid, stock_bus);
    end
    rst = 1'b0;
    #1;
    total++; if ({state, vend_valid, stock_bus, credit} !== {3'd0, 1'b0, 16'hFFFF, 8'd0}) begin
      bad++; $display("FAIL abort_reset state=%0d valid=%b stock=%h credit=%0d exp 0/0/ffff/0", state, vend_valid, stock_bus, credit);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    coin(8'd3);
    n = 0;
    while (state !== 3'd4 && n < 3 * TO) begin
      tick();
      n++;
    end
    total++; if (n !== TO + 1) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TO + 1); end
    total++; if ({chg_valid, chg_value} !== {1'b1, 8'd2}) begin bad++; $display("FAIL timeout_coin2 valid=%b value=%0d", chg_valid, chg_value); end
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
    n = 0;
    while (!chg_valid && n < 4 * GAP) begin
      tick();
      n++;
    end
    total++; if ({chg_valid, chg_value} !== {1'b1, 8'd1}) begin bad++; $display("FAIL timeout_coin1 valid=%b value=%0d", chg_valid, chg_value); end
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
    total++; if ({state, credit} !== {3'd0, 8'd0}) begin bad++; $display("FAIL timeout_done state=%0d credit=%0d", state, credit); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    coin_valid = 1'b0; coin_value = 8'd0;
    purchase_req = 1'b0; cancel_req = 1'b0; restock = 1'b0;
    vend_ack = 1'b0; chg_ack = 1'b0; item_sel = 2'd0;
    price_bus = {8'd20, 8'd10, 8'd3, 8'd6};
    test_reset();
    test_idle_purchase();
    test_purchase();
    test_overflow();
    test_sold_out();
    test_cancel_change();
    test_vend_abort();
`ifdef VEND_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
